// File: rtl/fpu_dispatch_pkg.sv
// Shared types and constants for the FP dispatcher (APU request/response initiator).
package fpu_dispatch_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned RM_W   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLAG_W = 5;

  localparam logic [RM_W-1:0]   RM_DYN    = 3'b111;
  localparam logic [DATA_W-1:0] CANON_NAN = 32'h7FC0_0000;

  // Bit positions follow the fflags CSR layout: NV is bit 4, NX is bit 0.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  function automatic logic [RM_W-1:0] resolve_rm(input logic [RM_W-1:0] rm,
                                                 input logic [RM_W-1:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

endpackage

// File: rtl/fpu_dispatch.sv
// FP dispatcher: issues one op over the APU req/gnt channel, waits for rvalid and
// writes back the result. The WAIT-state abort is enabled by FPU_DISPATCH_TIMEOUT_EN.
module fpu_dispatch
  import fpu_dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [OP_W-1:0]   issue_op_i,
  input  logic [RM_W-1:0]   issue_rm_i,
  input  logic [REG_W-1:0]  issue_rd_i,
  input  logic [DATA_W-1:0] issue_op1_i,
  input  logic [DATA_W-1:0] issue_op2_i,
  input  logic [DATA_W-1:0] issue_op3_i,
  input  logic [RM_W-1:0]   frm_i,
  output logic              busy_o,
  output logic              apu_req_o,
  input  logic              apu_gnt_i,
  output logic [DATA_W-1:0] apu_operands_o_1,
  output logic [DATA_W-1:0] apu_operands_o_2,
  output logic [DATA_W-1:0] apu_operands_o_3,
  output logic [OP_W-1:0]   apu_op_o,
  output logic [RM_W-1:0]   fp_rnd_mode_o,
  input  logic              apu_rvalid_i,
  input  logic [DATA_W-1:0] apu_rdata_i,
  input  logic [FLAG_W-1:0] apu_rflags_i,
  output logic              wb_valid_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              wb_err_o,
  output logic [FLAG_W-1:0] fflags_o,
  input  logic              fflags_clr_i
);

  state_t state_q, state_d;
  logic   accept;
  logic   capture;
  logic   abort;

  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] cap_data_q;
  fflags_t           cap_flags_q;
  logic              cmpl_pend_q;

`ifdef FPU_DISPATCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;
  logic             cap_err_q;
  logic             wb_err_q;
`endif

  assign issue_ready_o = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign apu_req_o     = (state_q == ST_REQ);
  assign accept        = issue_ready_o && issue_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every signal assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (issue_valid_i) state_d = ST_REQ;
      ST_REQ: begin
        if (apu_gnt_i) begin
          if (apu_rvalid_i) begin
            capture = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (apu_rvalid_i) begin
          capture = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef FPU_DISPATCH_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured at issue and stay stable for the whole handshake.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      apu_op_o         <= '0;
      apu_operands_o_1 <= '0;
      apu_operands_o_2 <= '0;
      apu_operands_o_3 <= '0;
      fp_rnd_mode_o    <= '0;
      rd_q             <= '0;
    end else if (accept) begin
      apu_op_o         <= issue_op_i;
      apu_operands_o_1 <= issue_op1_i;
      apu_operands_o_2 <= issue_op2_i;
      apu_operands_o_3 <= issue_op3_i;
      fp_rnd_mode_o    <= resolve_rm(issue_rm_i, frm_i);
      rd_q             <= issue_rd_i;
    end
  end

  // Response capture stage; writeback follows one cycle later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmpl_pend_q <= 1'b0;
      cap_data_q  <= '0;
      cap_flags_q <= '0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
      cap_err_q   <= 1'b0;
`endif
    end else begin
      cmpl_pend_q <= capture || abort;
      if (capture) begin
        cap_data_q  <= apu_rdata_i;
        cap_flags_q <= fflags_t'(apu_rflags_i);
`ifdef FPU_DISPATCH_TIMEOUT_EN
        cap_err_q   <= 1'b0;
      end else if (abort) begin
        cap_data_q  <= CANON_NAN;
        cap_flags_q <= '{nv: 1'b1, default: 1'b0};
        cap_err_q   <= 1'b1;
`endif
      end
    end
  end

  // A clear coincident with a completion leaves only the new flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_rd_o    <= '0;
      fflags_o   <= '0;
    end else begin
      wb_valid_o <= cmpl_pend_q;
      if (cmpl_pend_q) begin
        wb_data_o <= cap_data_q;
        wb_rd_o   <= rd_q;
      end
      fflags_o <= (fflags_clr_i ? '0 : fflags_o) | (cmpl_pend_q ? cap_flags_q : '0);
    end
  end

`ifdef FPU_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;
      if (cmpl_pend_q) wb_err_q <= cap_err_q;
    end
  end

  assign wb_err_o = wb_err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed self-checking bench for fpu_dispatch: vector table plus hand-written
// multi-cycle sequences (reset mid-op, ignored rvalid, back-to-back issue, timeout).
module tb_fpu_dispatch;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [4:0]  issue_op_i;
  logic [2:0]  issue_rm_i;
  logic [4:0]  issue_rd_i;
  logic [31:0] issue_op1_i, issue_op2_i, issue_op3_i;
  logic [2:0]  frm_i;
  logic        busy_o;
  logic        apu_req_o;
  logic        apu_gnt_i;
  logic [31:0] apu_operands_o_1, apu_operands_o_2, apu_operands_o_3;
  logic [4:0]  apu_op_o;
  logic [2:0]  fp_rnd_mode_o;
  logic        apu_rvalid_i;
  logic [31:0] apu_rdata_i;
  logic [4:0]  apu_rflags_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        wb_err_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i;

  int errors = 0;
  int checks = 0;

  fpu_dispatch #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_op_i(issue_op_i), .issue_rm_i(issue_rm_i), .issue_rd_i(issue_rd_i),
    .issue_op1_i(issue_op1_i), .issue_op2_i(issue_op2_i), .issue_op3_i(issue_op3_i),
    .frm_i(frm_i), .busy_o(busy_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o_1(apu_operands_o_1), .apu_operands_o_2(apu_operands_o_2),
    .apu_operands_o_3(apu_operands_o_3), .apu_op_o(apu_op_o),
    .fp_rnd_mode_o(fp_rnd_mode_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_err_o(wb_err_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  rm;
    logic [4:0]  rd;
    logic [31:0] op1, op2, op3;
    logic [2:0]  frm;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    logic [4:0]  rflags;
    logic        clr;
    logic [2:0]  exp_rm;
    logic [4:0]  exp_ff;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [2:0] rm, input logic [4:0] rd,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input logic [2:0] frm);
    issue_valid_i = 1'b1;
    issue_op_i    = op;
    issue_rm_i    = rm;
    issue_rd_i    = rd;
    issue_op1_i   = a;
    issue_op2_i   = b;
    issue_op3_i   = c;
    frm_i         = frm;
    tick();
    // Scramble the inputs so only registered copies can satisfy the checks.
    issue_valid_i = 1'b0;
    issue_op_i    = ~op;
    issue_rm_i    = ~rm;
    issue_rd_i    = ~rd;
    issue_op1_i   = ~a;
    issue_op2_i   = ~b;
    issue_op3_i   = ~c;
    frm_i         = ~frm;
  endtask

  task automatic check_req(input vec_t v, input string tag);
    check({tag, "_req"},  apu_req_o, 1'b1);
    check({tag, "_op"},   apu_op_o, v.op);
    check({tag, "_op1"},  apu_operands_o_1, v.op1);
    check({tag, "_op2"},  apu_operands_o_2, v.op2);
    check({tag, "_op3"},  apu_operands_o_3, v.op3);
    check({tag, "_rm"},   fp_rnd_mode_o, v.exp_rm);
    check({tag, "_busy"}, busy_o, 1'b1);
    check({tag, "_nowb"}, wb_valid_o, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_ready"}, issue_ready_o, 1'b1);
    drive_issue(v.op, v.rm, v.rd, v.op1, v.op2, v.op3, v.frm);
    check_req(v, tag);
    for (int i = 0; i < v.gnt_dly; i++) begin
      tick();
      check_req(v, {tag, "_hold"});
    end
    apu_gnt_i = 1'b1;
    if (v.rv_dly == 0) begin
      apu_rvalid_i = 1'b1;
      apu_rdata_i  = v.rdata;
      apu_rflags_i = v.rflags;
    end
    tick();
    apu_gnt_i    = 1'b0;
    apu_rvalid_i = 1'b0;
    if (v.rv_dly > 0) begin
      check({tag, "_wait_req"}, apu_req_o, 1'b0);
      check({tag, "_wait_busy"}, busy_o, 1'b1);
      repeat (v.rv_dly - 1) tick();
      apu_rvalid_i = 1'b1;
      apu_rdata_i  = v.rdata;
      apu_rflags_i = v.rflags;
      tick();
      apu_rvalid_i = 1'b0;
    end
    check({tag, "_cap_nowb"}, wb_valid_o, 1'b0);
    check({tag, "_cap_idle"}, issue_ready_o, 1'b1);
    fflags_clr_i = v.clr;
    tick();
    fflags_clr_i = 1'b0;
    check({tag, "_wb_valid"}, wb_valid_o, 1'b1);
    check({tag, "_wb_data"}, wb_data_o, v.rdata);
    check({tag, "_wb_rd"}, wb_rd_o, v.rd);
    check({tag, "_wb_err"}, wb_err_o, 1'b0);
    check({tag, "_fflags"}, fflags_o, v.exp_ff);
    tick();
    check({tag, "_pulse_end"}, wb_valid_o, 1'b0);
    check({tag, "_data_hold"}, wb_data_o, v.rdata);
  endtask

  vec_t vecs[5];

  initial begin
    int n;

    //            op     rm      rd     op1           op2           op3           frm     gd rd rdata         flags     clr   exp_rm  exp_ff
    vecs[0] = '{5'h00, 3'b000, 5'd5,  32'h3F800000, 32'h40000000, 32'h00000000, 3'b010, 0, 2, 32'h40400000, 5'b00000, 1'b0, 3'b000, 5'b00000};
    vecs[1] = '{5'h01, 3'b111, 5'd7,  32'hC0A00000, 32'h3F000000, 32'h12345678, 3'b010, 0, 0, 32'hC0200000, 5'b00001, 1'b0, 3'b010, 5'b00001};
    vecs[2] = '{5'h02, 3'b001, 5'd31, 32'h00000001, 32'h7F7FFFFF, 32'hFFFFFFFF, 3'b100, 5, 1, 32'h7F800000, 5'b10000, 1'b0, 3'b001, 5'b10001};
    vecs[3] = '{5'h03, 3'b111, 5'd1,  32'hAAAA5555, 32'h5555AAAA, 32'h0F0F0F0F, 3'b011, 1, 3, 32'h7FC00000, 5'b10000, 1'b1, 3'b011, 5'b10000};
    vecs[4] = '{5'h1F, 3'b110, 5'd12, 32'h80000000, 32'h00800000, 32'hDEADBEEF, 3'b000, 2, 0, 32'h00000000, 5'b00010, 1'b0, 3'b110, 5'b10010};

    rst_i = 1'b1;
    issue_valid_i = 1'b0; issue_op_i = '0; issue_rm_i = '0; issue_rd_i = '0;
    issue_op1_i = '0; issue_op2_i = '0; issue_op3_i = '0; frm_i = '0;
    apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0; apu_rdata_i = '0; apu_rflags_i = '0;
    fflags_clr_i = 1'b0;
    repeat (2) tick();

    check("rst_ready", issue_ready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req", apu_req_o, 1'b0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_err", wb_err_o, 1'b0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_wb_rd", wb_rd_o, 5'd0);
    check("rst_fflags", fflags_o, 5'd0);
    check("rst_op", apu_op_o, 5'd0);
    check("rst_opnd1", apu_operands_o_1, 32'h0);
    check("rst_rm", fp_rnd_mode_o, 3'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // rvalid while idle must be ignored.
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'hDEAD0000; apu_rflags_i = 5'b01000;
    tick();
    apu_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_rv_nowb", wb_valid_o, 1'b0);
    end
    check("idle_rv_fflags", fflags_o, 5'b10010);
    check("idle_rv_data", wb_data_o, 32'h00000000);

    // rvalid in REQ without gnt must be ignored; the real response follows later.
    drive_issue(5'h04, 3'b010, 5'd20, 32'h1, 32'h2, 32'h3, 3'b000);
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'hBAD0BAD0; apu_rflags_i = 5'b01000;
    tick();
    apu_rvalid_i = 1'b0;
    check("reqrv_still_req", apu_req_o, 1'b1);
    check("reqrv_nowb", wb_valid_o, 1'b0);
    apu_gnt_i = 1'b1;
    tick();
    apu_gnt_i = 1'b0;
    tick();
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h11111111; apu_rflags_i = 5'b00000;
    tick();
    apu_rvalid_i = 1'b0;
    tick();
    check("reqrv_wb_valid", wb_valid_o, 1'b1);
    check("reqrv_wb_data", wb_data_o, 32'h11111111);
    check("reqrv_wb_rd", wb_rd_o, 5'd20);
    check("reqrv_fflags", fflags_o, 5'b10010);

    // Best case followed by an issue accepted in the writeback cycle.
    tick();
    drive_issue(5'h05, 3'b000, 5'd3, 32'hA, 32'hB, 32'hC, 3'b000);
    apu_gnt_i = 1'b1; apu_rvalid_i = 1'b1; apu_rdata_i = 32'h22222222; apu_rflags_i = 5'b00000;
    tick();
    apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
    tick();
    check("b2b_first_wb", wb_valid_o, 1'b1);
    check("b2b_first_rd", wb_rd_o, 5'd3);
    check("b2b_ready_in_wb", issue_ready_o, 1'b1);
    drive_issue(5'h0A, 3'b100, 5'd9, 32'hD, 32'hE, 32'hF, 3'b000);
    check("b2b_second_req", apu_req_o, 1'b1);
    check("b2b_second_op", apu_op_o, 5'h0A);
    check("b2b_second_rm", fp_rnd_mode_o, 3'b100);
    check("b2b_first_pulse_end", wb_valid_o, 1'b0);
    apu_gnt_i = 1'b1; apu_rvalid_i = 1'b1; apu_rdata_i = 32'h33333333; apu_rflags_i = 5'b00100;
    tick();
    apu_gnt_i = 1'b0; apu_rvalid_i = 1'b0;
    tick();
    check("b2b_second_wb", wb_valid_o, 1'b1);
    check("b2b_second_data", wb_data_o, 32'h33333333);
    check("b2b_second_rd", wb_rd_o, 5'd9);
    check("b2b_fflags", fflags_o, 5'b10110);

    // Standalone clear.
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    check("clr_alone", fflags_o, 5'b00000);

    // Reset while waiting: op discarded, late rvalid ignored.
    drive_issue(5'h06, 3'b000, 5'd14, 32'h5, 32'h6, 32'h7, 3'b000);
    apu_gnt_i = 1'b1;
    tick();
    apu_gnt_i = 1'b0;
    check("rstwait_busy", busy_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("rstwait_async_ready", issue_ready_o, 1'b1);
    check("rstwait_async_req", apu_req_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h44444444; apu_rflags_i = 5'b11111;
    tick();
    apu_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstwait_nowb", wb_valid_o, 1'b0);
    end
    check("rstwait_ready", issue_ready_o, 1'b1);
    check("rstwait_busy_low", busy_o, 1'b0);
    check("rstwait_fflags", fflags_o, 5'b00000);
    check("rstwait_wb_data", wb_data_o, 32'h0);

`ifdef FPU_DISPATCH_TIMEOUT_EN
    // Timeout abort after 8 WAIT cycles, writeback one cycle later.
    drive_issue(5'h07, 3'b000, 5'd22, 32'h8, 32'h9, 32'hA, 3'b000);
    apu_gnt_i = 1'b1;
    tick();
    apu_gnt_i = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (wb_valid_o === 1'b1) begin
        n = i;
        break;
      end
    end
    check("to_latency", n, 9);
    check("to_wb_err", wb_err_o, 1'b1);
    check("to_wb_data", wb_data_o, 32'h7FC00000);
    check("to_wb_rd", wb_rd_o, 5'd22);
    check("to_fflags_nv", fflags_o[4], 1'b1);
    check("to_ready", issue_ready_o, 1'b1);
`else
    n = 0;
    drive_issue(5'h07, 3'b000, 5'd22, 32'h8, 32'h9, 32'hA, 3'b000);
    apu_gnt_i = 1'b1;
    tick();
    apu_gnt_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wb_valid_o === 1'b1) n++;
    end
    check("nto_no_abort", n, 0);
    check("nto_still_busy", busy_o, 1'b1);
    check("nto_err_low", wb_err_o, 1'b0);
    apu_rvalid_i = 1'b1; apu_rdata_i = 32'h55555555; apu_rflags_i = 5'b00000;
    tick();
    apu_rvalid_i = 1'b0;
    tick();
    check("nto_late_wb", wb_valid_o, 1'b1);
    check("nto_late_data", wb_data_o, 32'h55555555);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_dispatch.md
# fpu_dispatch

Initiator side of the APU request/response protocol used by the floating-point unit. Sits in the processor EX stage between FP instruction decode and the FPU ALU: accepts one FP operation at a time, drives the req/gnt request channel, waits for the rvalid response, and returns the result, destination register and exception flags to writeback. It also maintains the sticky `fflags` accumulator and resolves dynamic rounding mode against `frm`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: WAIT-state cycles before abort. Used only with the timeout feature; minimum 2.

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `issue_valid_i`  in  1  EX presents an FP op
- `issue_ready_o`  out  1  dispatcher idle, can accept an op
- `issue_op_i`  in  5  APU opcode
- `issue_rm_i`  in  3  instruction rm field (3'b111 = dynamic)
- `issue_rd_i`  in  5  destination register index
- `issue_op1_i`, `issue_op2_i`, `issue_op3_i`  in  32 each  source operands
- `frm_i`  in  3  CSR dynamic rounding mode
- `busy_o`  out  1  op in flight; EX holds while high
- `apu_req_o`  out  1  request valid
- `apu_gnt_i`  in  1  request accepted
- `apu_operands_o_1/_2/_3`  out  32 each  registered operands
- `apu_op_o`  out  5  registered opcode
- `fp_rnd_mode_o`  out  3  resolved rounding mode
- `apu_rvalid_i`  in  1  response valid
- `apu_rdata_i`  in  32  result
- `apu_rflags_i`  in  5  NV,DZ,OF,UF,NX (bit 4..0)
- `wb_valid_o`  out  1  one-cycle result pulse
- `wb_rd_o`  out  5  destination index
- `wb_data_o`  out  32  result
- `wb_err_o`  out  1  result produced by timeout abort
- `fflags_o`  out  5  sticky accumulated flags
- `fflags_clr_i`  in  1  clear accumulator (CSR write)

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: `issue_ready_o`=1. On `issue_valid_i`, register op, operands, rd and resolved rm; go REQ.
- Resolved rm = `issue_rm_i`==3'b111 ? `frm_i` : `issue_rm_i`; 3'b101/3'b110 forwarded unchanged (decode traps them).
- REQ: `apu_req_o`=1, request fields stable. On `apu_gnt_i`: go WAIT; if `apu_rvalid_i` also high that cycle, complete immediately and go IDLE.
- WAIT: `apu_req_o`=0. On `apu_rvalid_i`: capture `apu_rdata_i`, flags; go IDLE.
- Completion: next cycle `wb_valid_o`=1 with `wb_data_o`, `wb_rd_o`; `fflags_o` |= captured flags in the same edge.
- `apu_rvalid_i` in IDLE, or in REQ without gnt, is ignored.
- `fflags_clr_i`: `fflags_o` <= 0; if coincident with a completion, result = captured flags only (clear first, then OR).
- `busy_o` = state != IDLE.

## Timing
- Reset values: state IDLE; `apu_req_o`, `wb_valid_o`, `wb_err_o` 0; all data/index/flag outputs 0; `fflags_o` 0.
- Reset mid-operation: return to IDLE immediately, in-flight op discarded, no wb pulse.
- Issue→req: 1 cycle. Best case issue to `wb_valid_o`: 3 cycles (gnt and rvalid together in REQ).
- `wb_valid_o` high for exactly one cycle per accepted op; `wb_data_o`/`wb_rd_o` hold until next completion.
- New issue accepted in the same cycle `wb_valid_o` is high.

## Configuration
- `FPU_DISPATCH_TIMEOUT_EN` defined: counter runs in WAIT; at `TIMEOUT_CYCLES` cycles without rvalid, go IDLE, pulse `wb_valid_o` with `wb_data_o`=32'h7FC00000, `wb_err_o`=1, and OR NV (5'b10000) into `fflags_o`. Counter clears on entering WAIT.
- Not defined: no counter, WAIT indefinitely, `wb_err_o` tied 0.

## Structure
- Package `fpu_dispatch_pkg`: state enum, `RM_DYN`=3'b111, canonical NaN constant, flag bit indices, opcode width localparams.
- Single module; no sub-module needed.

## Test plan
- FADD op1=32'h3F800000, op2=32'h40000000, rm=000, gnt in REQ, rvalid 2 cycles later with 32'h40400000 flags 0 -> one `wb_valid_o`, data 32'h40400000, correct rd, `fflags_o`=0.
- rm=111 with `frm_i`=010 -> `fp_rnd_mode_o`=010 during REQ; rm=001 -> 001.
- gnt held low 5 cycles -> `apu_req_o` and all request fields stable for 5+ cycles, no completion.
- Two ops returning flags 00001 then 10000 -> `fflags_o`=10001; `fflags_clr_i` coincident with second completion -> 10000.
- `rst_i` asserted in WAIT, rvalid arrives after release -> no `wb_valid_o`, state IDLE, `issue_ready_o`=1.
- With `FPU_DISPATCH_TIMEOUT_EN`, TIMEOUT_CYCLES=8, no rvalid -> after 8 WAIT cycles `wb_err_o`=1, data 32'h7FC00000, `fflags_o[4]`=1.
